// File: rtl/fft_mag_stream.sv
// fft_mag_stream: streams FFT bins to the pitch detector as approximate
// magnitudes |X| ~= max + min/4 + min/8, tagged with bin index and frame end.
// Ports: clk/resetn (sync, active-low), fft_npoint (128/256/else 512),
//   s_tvalid/s_tready/s_tdata_re/s_tdata_im/s_tlast input stream,
//   mag_valid/magnitude/point_index/mag_last/frame_err output beats,
//   frame_count completed-frame counter (wraps).
module fft_mag_stream #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [9:0]             fft_npoint,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [15:0]            s_tdata_re,
  input  logic [15:0]            s_tdata_im,
  input  logic                   s_tlast,
  output logic                   mag_valid,
  output logic [15:0]            magnitude,
  output logic [9:0]             point_index,
  output logic                   mag_last,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  typedef enum logic {RUN, RESYNC} state_t;

  state_t      r_state;
  logic [9:0]  r_in_idx;
  logic [9:0]  r_nlast_q;

  logic        r0_v, r0_last, r0_err;
  logic [15:0] r0_re, r0_im;
  logic [9:0]  r0_idx;

  logic        r1_v, r1_last, r1_err;
  logic [15:0] r1_a, r1_b;
  logic [9:0]  r1_idx;

  logic        r2_v, r2_last, r2_err;
  logic [15:0] r2_mx, r2_mn;
  logic [9:0]  r2_idx;

  logic [9:0]  w_dec_nlast;
  logic [9:0]  w_nlast;
  logic        w_acc;
  logic        w_at_end;
  logic [16:0] w_sum;

  function automatic logic [15:0] abs16(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7fff;
    else if (x[15]) return 16'(-x);
    else return x;
  endfunction

  always_comb begin
    w_dec_nlast = 10'd511;
    case (fft_npoint)
      10'd128: w_dec_nlast = 10'd127;
      10'd256: w_dec_nlast = 10'd255;
      default: w_dec_nlast = 10'd511;
    endcase
  end

  // The first beat of a frame uses the length being latched on that beat.
  assign w_nlast  = (r_in_idx == 10'd0) ? w_dec_nlast : r_nlast_q;
  assign w_acc    = s_tvalid && s_tready;
  assign w_at_end = (r_in_idx == w_nlast);

  // Frame tracking and input capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= RUN;
      r_in_idx    <= '0;
      r_nlast_q   <= 10'd511;
      s_tready    <= 1'b0;
      frame_count <= '0;
      r0_v        <= 1'b0;
      r0_re       <= '0;
      r0_im       <= '0;
      r0_idx      <= '0;
      r0_last     <= 1'b0;
      r0_err      <= 1'b0;
    end else begin
      s_tready <= 1'b1;
      r0_v     <= 1'b0;
      if (w_acc) begin
        unique case (r_state)
          RUN: begin
            r0_v   <= 1'b1;
            r0_re  <= s_tdata_re;
            r0_im  <= s_tdata_im;
            r0_idx <= r_in_idx;
            if (r_in_idx == 10'd0) r_nlast_q <= w_dec_nlast;
            if (w_at_end || s_tlast) begin
              r0_last     <= 1'b1;
              r0_err      <= !(w_at_end && s_tlast);
              r_in_idx    <= '0;
              frame_count <= frame_count + 1'b1;
              if (w_at_end && !s_tlast) r_state <= RESYNC;
            end else begin
              r0_last  <= 1'b0;
              r0_err   <= 1'b0;
              r_in_idx <= r_in_idx + 10'd1;
            end
          end
          RESYNC: begin
            if (s_tlast) begin
              r_state  <= RUN;
              r_in_idx <= '0;
            end
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  // Stage 1: absolute values
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r1_v    <= 1'b0;
      r1_a    <= '0;
      r1_b    <= '0;
      r1_idx  <= '0;
      r1_last <= 1'b0;
      r1_err  <= 1'b0;
    end else begin
      r1_v    <= r0_v;
      r1_a    <= abs16(r0_re);
      r1_b    <= abs16(r0_im);
      r1_idx  <= r0_idx;
      r1_last <= r0_last;
      r1_err  <= r0_err;
    end
  end

  // Stage 2: max / min ordering
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r2_v    <= 1'b0;
      r2_mx   <= '0;
      r2_mn   <= '0;
      r2_idx  <= '0;
      r2_last <= 1'b0;
      r2_err  <= 1'b0;
    end else begin
      r2_v    <= r1_v;
      r2_mx   <= (r1_a >= r1_b) ? r1_a : r1_b;
      r2_mn   <= (r1_a >= r1_b) ? r1_b : r1_a;
      r2_idx  <= r1_idx;
      r2_last <= r1_last;
      r2_err  <= r1_err;
    end
  end

  // Peak is 32767 + 8191 + 4095 = 45053, so the 16-bit slice is exact.
  assign w_sum = 17'(r2_mx) + 17'(r2_mn >> 2) + 17'(r2_mn >> 3);

  // Stage 3: registered output beat, tags zeroed on idle cycles
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mag_valid   <= 1'b0;
      magnitude   <= '0;
      point_index <= '0;
      mag_last    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      mag_valid   <= r2_v;
      magnitude   <= r2_v ? w_sum[15:0] : 16'd0;
      point_index <= r2_v ? r2_idx : 10'd0;
      mag_last    <= r2_v && r2_last;
      frame_err   <= r2_v && r2_err;
    end
  end

endmodule

// File: tb/tb_fft_mag_stream.sv
// tb_fft_mag_stream: random-stimulus scoreboard bench for fft_mag_stream.
// Reference model applies the frame rules per accepted beat; monitor checks.
module tb_fft_mag_stream;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  fft_npoint = 10'd128;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata_re = '0;
  logic [15:0] s_tdata_im = '0;
  logic        s_tlast = 1'b0;
  logic        mag_valid;
  logic [15:0] magnitude;
  logic [9:0]  point_index;
  logic        mag_last;
  logic        frame_err;
  logic [15:0] frame_count;

  fft_mag_stream #(.FRAME_CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .fft_npoint(fft_npoint),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata_re(s_tdata_re), .s_tdata_im(s_tdata_im),
    .s_tlast(s_tlast), .mag_valid(mag_valid),
    .magnitude(magnitude), .point_index(point_index),
    .mag_last(mag_last), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mag; int idx; bit last; bit err; int due;
  } exp_t;
  exp_t q[$];

  int nvec = 0;
  int nmis = 0;

  // reference model state
  bit          m_resync = 0;
  int          m_idx = 0;
  int          m_n = 512;
  logic [15:0] m_fc = '0;
  bit          exp_rdy = 0;
  bit          prev_rst = 1;

  function automatic int mabs(input int v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int dec_n(input int n);
    if (n == 128 || n == 256) return n;
    return 512;
  endfunction

  task automatic model_accept(input logic [15:0] r, input logic [15:0] i,
                              input bit l);
    exp_t e;
    int a, b, mx, mn;
    if (m_resync) begin
      if (l) begin m_resync = 0; m_idx = 0; end
      return;
    end
    if (m_idx == 0) m_n = dec_n(int'(fft_npoint));
    a  = mabs(int'($signed(r)));
    b  = mabs(int'($signed(i)));
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    e.mag  = mx + mn / 4 + mn / 8;
    e.idx  = m_idx;
    e.due  = cyc + 4;
    e.last = 0;
    e.err  = 0;
    if (m_idx == m_n - 1) begin
      e.last = 1; e.err = !l; m_fc++; m_idx = 0;
      if (!l) m_resync = 1;
    end else if (l) begin
      e.last = 1; e.err = 1; m_fc++; m_idx = 0;
    end else begin
      m_idx++;
    end
    q.push_back(e);
  endtask

  task automatic step(input bit rn, input bit v, input logic [15:0] r,
                      input logic [15:0] i, input bit l, output bit acc);
    @(negedge clk);
    #1;
    nvec++;
    if (s_tready !== exp_rdy || frame_count !== m_fc ||
        (prev_rst && (mag_valid !== 1'b0 || magnitude !== 16'd0 ||
         point_index !== 10'd0 || mag_last !== 1'b0 ||
         frame_err !== 1'b0))) begin
      nmis++;
      $display("FAIL ctrl t=%0t: tready=%b fc=%0d mv=%b mag=%0d want tready=%b fc=%0d inrst=%b",
               $time, s_tready, frame_count, mag_valid, magnitude,
               exp_rdy, m_fc, prev_rst);
    end
    resetn     = rn;
    s_tvalid   = v;
    s_tdata_re = r;
    s_tdata_im = i;
    s_tlast    = l;
    acc = 0;
    if (!rn) begin
      q.delete();
      m_resync = 0; m_idx = 0; m_fc = '0; exp_rdy = 0;
    end else begin
      if (v && exp_rdy) begin
        acc = 1;
        model_accept(r, i, l);
      end
      exp_rdy = 1;
    end
    prev_rst = !rn;
  endtask

  // nb beats; last_at = beat index carrying s_tlast (-1 none); fixed data opt.
  task automatic frame(input int nb, input int last_at, input bit gaps,
                       input bit fixed, input logic [15:0] fr,
                       input logic [15:0] fi);
    int k = 0;
    bit v, acc;
    logic [15:0] r, i;
    while (k < nb) begin
      v = gaps ? ($urandom_range(3) != 0) : 1'b1;
      r = fixed ? fr : 16'($urandom);
      i = fixed ? fi : 16'($urandom);
      step(1'b1, v, r, i, v && (k == last_at), acc);
      if (acc) k++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mag_valid === 1'b1) begin
      nvec++;
      if (q.size() == 0) begin
        nmis++;
        $display("FAIL beat_unexpected t=%0t: idx=%0d mag=%0d, none expected",
                 $time, point_index, magnitude);
      end else begin
        e = q.pop_front();
        if (cyc != e.due || int'(magnitude) != e.mag ||
            int'(point_index) != e.idx || mag_last != e.last ||
            frame_err != e.err) begin
          nmis++;
          $display("FAIL beat t=%0t: cyc=%0d mag=%0d idx=%0d last=%b err=%b want cyc=%0d mag=%0d idx=%0d last=%b err=%b",
                   $time, cyc, magnitude, point_index, mag_last, frame_err,
                   e.due, e.mag, e.idx, e.last, e.err);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      nvec++;
      nmis++;
      e = q.pop_front();
      $display("FAIL beat_missing t=%0t: mag_valid=0, want idx=%0d mag=%0d",
               $time, e.idx, e.mag);
    end
  end

  initial begin
    bit acc;
    int n;
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, '0, '0, 1'b0, acc);
    step(1'b1, 1'b0, '0, '0, 1'b0, acc);

    // clean 128-point frame with fixed bins
    fft_npoint = 10'd128;
    frame(128, 127, 1'b0, 1'b1, 16'd3000, 16'd4000);

    // extreme values then finish the frame
    step(1'b1, 1'b1, 16'h8000, 16'd0, 1'b0, acc);
    step(1'b1, 1'b1, 16'h7fff, 16'h8001, 1'b0, acc);
    step(1'b1, 1'b1, 16'd0, 16'd0, 1'b0, acc);
    step(1'b1, 1'b1, 16'hff9c, 16'd40, 1'b0, acc);
    frame(124, 123, 1'b1, 1'b0, '0, '0);

    // early s_tlast at 256, then clean frame
    fft_npoint = 10'd256;
    frame(100, 99, 1'b1, 1'b0, '0, '0);
    frame(256, 255, 1'b1, 1'b0, '0, '0);

    // missing s_tlast, resync beats, clean frame
    fft_npoint = 10'd128;
    frame(128, -1, 1'b1, 1'b0, '0, '0);
    frame(5, 4, 1'b1, 1'b0, '0, '0);
    frame(128, 127, 1'b1, 1'b0, '0, '0);

    // length change mid-frame, then 512 and an undecoded length
    frame(50, -1, 1'b0, 1'b0, '0, '0);
    fft_npoint = 10'd512;
    frame(78, 77, 1'b1, 1'b0, '0, '0);
    frame(512, 511, 1'b1, 1'b0, '0, '0);
    fft_npoint = 10'd300;
    frame(512, 511, 1'b0, 1'b0, '0, '0);

    // reset mid-frame with s_tvalid held
    fft_npoint = 10'd128;
    frame(60, -1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, acc);
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, acc);
    frame(128, 127, 1'b1, 1'b0, '0, '0);

    // random frames with random lengths and tlast placement
    for (int f = 0; f < 6; f++) begin
      fft_npoint = ($urandom_range(1) == 0) ? 10'd128 : 10'd256;
      n = int'(fft_npoint);
      if ($urandom_range(2) == 0)
        frame($urandom_range(n - 2) + 1, -2, 1'b1, 1'b0, '0, '0);
      else
        frame(n, n - 1, 1'b1, 1'b0, '0, '0);
    end
    fft_npoint = 10'd128;
    frame(128, 127, 1'b1, 1'b0, '0, '0);

    for (int j = 0; j < 12; j++) step(1'b1, 1'b0, '0, '0, 1'b0, acc);
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d beats outstanding, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
